// File: rtl/store_pkg.sv
// Shared definitions for the store narrowing path: access-size encodings and
// the layout of one already-narrowed FIFO entry.
package store_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Word address only; the low two address bits are implied by the byte enables.
  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } entry_t;

  // Rebuild a byte address from a stored word address.
  function automatic logic [31:0] word_to_byte_addr(input logic [29:0] waddr);
    return {waddr, 2'b00};
  endfunction

endpackage

// File: rtl/store_lane_align.sv
// Combinational lane steering for a store: replicates the narrow operand across
// the byte lanes, builds the little-endian byte-enable mask and flags accesses
// that are misaligned or use the illegal size encoding.
module store_lane_align
  import store_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic [31:0] data_in,
  output logic [31:0] data,
  output logic [3:0]  be,
  output logic        bad
);

  // Per-size lane rules; illegal encodings produce an empty mask and bad=1.
  always_comb begin
    data = '0;
    be   = '0;
    bad  = 1'b0;
    case (size)
      SZ_BYTE: begin
        data = {4{data_in[7:0]}};
        be   = 4'b0001 << addr_lo;
      end
      SZ_HALF: begin
        data = {2{data_in[15:0]}};
        be   = addr_lo[1] ? 4'b1100 : 4'b0011;
        bad  = addr_lo[0];
      end
      SZ_WORD: begin
        data = data_in;
        be   = 4'b1111;
        bad  = (addr_lo != 2'b00);
      end
      default: begin
        bad  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/store_narrow_buffer.sv
// Store narrowing buffer between MEM and the data-memory write port.
// Requests are narrowed on entry and queued in a DEPTH-entry circular FIFO.
// Misaligned requests are consumed but dropped, with a registered one-cycle
// misaligned pulse. flush and rst both empty the queue; rst also clears the pulse.
module store_narrow_buffer
  import store_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_addr,
  input  logic [31:0]              in_data,
  input  logic [1:0]               in_size,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_addr,
  output logic [31:0]              out_data,
  output logic [3:0]               out_be,
  output logic                     misaligned,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             misaligned_q, misaligned_d;
  entry_t           mem_q [DEPTH];

  logic [31:0] lane_data;
  logic [3:0]  lane_be;
  logic        lane_bad;
  logic        accept;
  logic        push;
  logic        pop;
  entry_t      new_entry;
  entry_t      head;

  store_lane_align u_align (
    .addr_lo (in_addr[1:0]),
    .size    (in_size),
    .data_in (in_data),
    .data    (lane_data),
    .be      (lane_be),
    .bad     (lane_bad)
  );

  // Handshake decode: a rejected request still completes its handshake.
  always_comb begin
    in_ready       = (count_q < DEPTH_C);
    out_valid      = (count_q != '0);
    accept         = in_valid & in_ready;
    push           = accept & ~lane_bad;
    pop            = out_valid & out_ready;
    new_entry.addr = in_addr[31:2];
    new_entry.data = lane_data;
    new_entry.be   = lane_be;
  end

  // Next-state for pointers, occupancy and the misaligned pulse; flush wins.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    misaligned_d = accept & lane_bad;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      misaligned_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Entry storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) begin
      mem_q[wr_ptr_q] <= new_entry;
    end
  end

  // Head presentation, zeroed while the queue is empty.
  always_comb begin
    head       = mem_q[rd_ptr_q];
    out_addr   = out_valid ? word_to_byte_addr(head.addr) : '0;
    out_data   = out_valid ? head.data : '0;
    out_be     = out_valid ? head.be : '0;
    misaligned = misaligned_q;
    count      = count_q;
  end

endmodule
